// File: rtl/lcd_pkg.sv
// Shared constants, types and address helpers for the HD44780-style bus responder.
// The display model keeps 2 lines x 16 visible cells out of the 2 x 40 DDRAM map.
package lcd_pkg;

    localparam int DEFAULT_BUSY_CYCLES       = 2000;
    localparam int DEFAULT_CLEAR_BUSY_CYCLES = 82000;
    localparam int NUM_CELLS                 = 32;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE0_END  = 7'h27;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = 7'h67;

    localparam logic [7:0] OP_SET_DDRAM    = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM    = 8'h40;
    localparam logic [7:0] OP_FUNCTION_SET = 8'h20;
    localparam logic [7:0] OP_SHIFT        = 8'h10;
    localparam logic [7:0] OP_DISPLAY_CTRL = 8'h08;
    localparam logic [7:0] OP_ENTRY_MODE   = 8'h04;
    localparam logic [7:0] OP_RETURN_HOME  = 8'h02;
    localparam logic [7:0] OP_CLEAR        = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_SWEEP,
        BUSY_WAIT
    } lcd_state_t;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISPLAY,
        CMD_SHIFT,
        CMD_FUNCTION,
        CMD_CGRAM,
        CMD_SET_DDRAM
    } lcd_cmd_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] index;
    } cell_ref_t;

    // The highest set bit selects the instruction.
    function automatic lcd_cmd_t decode_cmd(input logic [7:0] op);
        if ((op & OP_SET_DDRAM) != 8'h00)         return CMD_SET_DDRAM;
        else if ((op & OP_SET_CGRAM) != 8'h00)    return CMD_CGRAM;
        else if ((op & OP_FUNCTION_SET) != 8'h00) return CMD_FUNCTION;
        else if ((op & OP_SHIFT) != 8'h00)        return CMD_SHIFT;
        else if ((op & OP_DISPLAY_CTRL) != 8'h00) return CMD_DISPLAY;
        else if ((op & OP_ENTRY_MODE) != 8'h00)   return CMD_ENTRY;
        else if ((op & OP_RETURN_HOME) != 8'h00)  return CMD_HOME;
        else if ((op & OP_CLEAR) != 8'h00)        return CMD_CLEAR;
        else                                      return CMD_NONE;
    endfunction

    function automatic logic [6:0] fold_addr(input logic [6:0] a);
        if (a <= LINE0_END)     return a;
        else if (a < LINE1_BASE) return LINE0_BASE;
        else if (a <= LINE1_END) return a;
        else                     return LINE1_BASE;
    endfunction

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == LINE0_END) return LINE1_BASE;
            if (a == LINE1_END) return LINE0_BASE;
            return a + 7'd1;
        end
        if (a == LINE0_BASE) return LINE1_END;
        if (a == LINE1_BASE) return LINE0_END;
        return a - 7'd1;
    endfunction

    function automatic cell_ref_t map_cell(input logic [6:0] a);
        cell_ref_t r;
        r.valid = (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
        r.index = {a[6], a[3:0]};
        return r;
    endfunction

endpackage

// File: rtl/lcd_in_sync.sv
// Enable-strobe synchronizer and commit detector. A commit fires on the falling
// edge of the synchronized strobe, but only for a strobe that rose after reset.
module lcd_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic lcd_en,
    output logic en_sync,
    output logic en_fall
);

    logic en_meta;
    logic en_d;
    logic live;
    logic armed;
    logic open;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_meta <= 1'b0;
            en_sync <= 1'b0;
            en_d    <= 1'b0;
            live    <= 1'b0;
            armed   <= 1'b0;
            open    <= 1'b0;
        end else begin
            en_meta <= lcd_en;
            en_sync <= en_meta;
            en_d    <= en_sync;
            live    <= 1'b1;
            // A strobe only counts once a genuine low has been seen after reset.
            if (live && !en_meta)
                armed <= 1'b1;
            if (en_sync && !en_d && armed)
                open <= 1'b1;
            else if (en_fall)
                open <= 1'b0;
        end
    end

    assign en_fall = en_d && !en_sync && open;

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus target: decodes committed transactions, keeps the visible
// character cells, address counter and busy timing, and answers read strobes.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES       = DEFAULT_BUSY_CYCLES,
    parameter int CLEAR_BUSY_CYCLES = DEFAULT_CLEAR_BUSY_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [4:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       display_on,
    output logic       busy,
    output logic       cmd_err
);

    localparam int CNT_W = $clog2(CLEAR_BUSY_CYCLES + 1);

    logic             en_sync;
    logic             en_fall;
    logic             rs_q;
    logic             rw_q;
    logic [7:0]       data_q;
    logic [6:0]       ac_q;
    logic             inc_q;
    logic [CNT_W-1:0] busy_cnt;
    logic [4:0]       sweep_idx;
    logic [7:0]       cells [NUM_CELLS];
    lcd_state_t       state_q;
    lcd_state_t       state_d;
    lcd_cmd_t         cmd;
    cell_ref_t        cur_cell;
    logic             accept;
    logic             reject;
    logic             start_write;
    logic             start_clear;

    lcd_in_sync u_in_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .lcd_en  (lcd_en),
        .en_sync (en_sync),
        .en_fall (en_fall)
    );

    assign busy        = (busy_cnt != '0);
    assign cmd         = decode_cmd(data_q);
    assign cur_cell    = map_cell(ac_q);
    // Status reads never change state, so only writes and data reads are gated by busy.
    assign accept      = en_fall && !busy && (!rw_q || rs_q);
    assign reject      = en_fall &&  busy && (!rw_q || rs_q);
    assign start_write = accept && !rw_q;
    assign start_clear = start_write && !rs_q && (cmd == CMD_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_clear)      state_d = CLEAR_SWEEP;
                else if (start_write) state_d = BUSY_WAIT;
            end
            CLEAR_SWEEP: begin
                if (sweep_idx == 5'(NUM_CELLS - 1)) state_d = BUSY_WAIT;
            end
            BUSY_WAIT: begin
                if (busy_cnt <= CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt  <= '0;
            sweep_idx <= '0;
        end else begin
            if (start_write)
                busy_cnt <= start_clear ? CNT_W'(CLEAR_BUSY_CYCLES) : CNT_W'(BUSY_CYCLES);
            else if (busy)
                busy_cnt <= busy_cnt - CNT_W'(1);
            if (start_clear)
                sweep_idx <= '0;
            else if (state_q == CLEAR_SWEEP)
                sweep_idx <= sweep_idx + 5'd1;
        end
    end

    // NOTE: the cell array is plain flops, so it resets with everything else to the blank display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CELLS; i++)
                cells[i] <= SPACE_CHAR;
        end else if (state_q == CLEAR_SWEEP) begin
            cells[sweep_idx] <= SPACE_CHAR;
        end else if (start_write && rs_q && cur_cell.valid) begin
            cells[cur_cell.index] <= data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            data_q     <= 8'h00;
            ac_q       <= LINE0_BASE;
            inc_q      <= 1'b1;
            display_on <= 1'b0;
            cmd_err    <= 1'b0;
            disp_char  <= SPACE_CHAR;
        end else begin
            cmd_err   <= reject;
            disp_char <= cells[disp_addr];
            if (en_sync) begin
                rs_q   <= lcd_rs;
                rw_q   <= lcd_rw;
                data_q <= lcd_data_in;
            end
            if (accept) begin
                if (rs_q) begin
                    ac_q <= step_addr(ac_q, inc_q);
                end else begin
                    case (cmd)
                        CMD_SET_DDRAM: ac_q <= fold_addr(data_q[6:0]);
                        CMD_SHIFT:     if (!data_q[3]) ac_q <= step_addr(ac_q, data_q[2]);
                        CMD_DISPLAY:   display_on <= data_q[2];
                        CMD_ENTRY:     inc_q <= data_q[1];
                        CMD_HOME:      ac_q <= LINE0_BASE;
                        CMD_CLEAR: begin
                            ac_q  <= LINE0_BASE;
                            inc_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign lcd_data_oe = en_sync && rw_q;

    always_comb begin
        lcd_data_out = 8'h00;
        if (lcd_data_oe) begin
            if (!rs_q)
                lcd_data_out = {busy, ac_q};
            else if (!busy)
                lcd_data_out = cur_cell.valid ? cells[cur_cell.index] : SPACE_CHAR;
        end
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench: drives HD44780 bus strobes and compares against a
// behavioural display model built from the address/command rules.
module tb_lcd_bus_responder;

    localparam int BUSY  = 8;
    localparam int CLEAR = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_en = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [4:0] disp_addr = 5'd0;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [7:0] disp_char;
    logic       display_on;
    logic       busy;
    logic       cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_cells [32];
    int         m_ac;
    bit         m_inc;
    bit         m_disp_on;

    lcd_bus_responder #(.BUSY_CYCLES(BUSY), .CLEAR_BUSY_CYCLES(CLEAR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcd_en       (lcd_en),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .disp_addr    (disp_addr),
        .disp_char    (disp_char),
        .display_on   (display_on),
        .busy         (busy),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic int m_fold(input int a);
        if (a <= 39) return a;
        if (a < 64)  return 0;
        if (a <= 103) return a;
        return 64;
    endfunction

    function automatic int m_step(input int a, input bit inc);
        if (inc) begin
            if (a == 39)  return 64;
            if (a == 103) return 0;
            return a + 1;
        end
        if (a == 0)  return 103;
        if (a == 64) return 39;
        return a - 1;
    endfunction

    function automatic int m_index(input int a);
        if (a < 16) return a;
        if (a >= 64 && a < 80) return a - 48;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
        m_ac = 0;
        m_inc = 1'b1;
        m_disp_on = 1'b0;
    endtask

    task automatic m_command(input logic [7:0] c);
        if (c[7])      m_ac = m_fold(int'(c[6:0]));
        else if (c[6]) ;
        else if (c[5]) ;
        else if (c[4]) begin
            if (!c[3]) m_ac = m_step(m_ac, c[2]);
        end
        else if (c[3]) m_disp_on = c[2];
        else if (c[2]) m_inc = c[1];
        else if (c[1]) m_ac = 0;
        else if (c[0]) begin
            for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
            m_ac = 0;
            m_inc = 1'b1;
        end
    endtask

    task automatic m_data_write(input logic [7:0] d);
        int idx;
        idx = m_index(m_ac);
        if (idx >= 0) m_cells[idx] = d;
        m_ac = m_step(m_ac, m_inc);
    endtask

    task automatic m_data_read(output logic [7:0] d);
        int idx;
        idx = m_index(m_ac);
        d = (idx >= 0) ? m_cells[idx] : 8'h20;
        m_ac = m_step(m_ac, m_inc);
    endtask

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'(m_ac);
        s[7] = 1'b0;
        return s;
    endfunction

    // ---------------- bus stimulus ----------------
    task automatic wait_busy_rise(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_commit: busy never rose, got 0 expected 1", tag);
        end
    endtask

    task automatic wait_busy_fall(input string tag);
        bit ok;
        ok = !busy;
        for (int i = 0; i < CLEAR + 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_idle: busy stuck, got 1 expected 0", tag);
        end
    endtask

    task automatic start_strobe(input bit rs, input bit rw, input logic [7:0] d, input int high_cycles);
        @(negedge clk);
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_data_in = d;
        lcd_en = 1'b1;
        repeat (high_cycles) @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic bus_write(input bit rs, input logic [7:0] d);
        start_strobe(rs, 1'b0, d, 4);
        wait_busy_rise("write");
        wait_busy_fall("write");
        if (rs) m_data_write(d);
        else    m_command(d);
    endtask

    task automatic bus_read(input bit rs, output logic [7:0] val, output logic oe);
        @(negedge clk);
        lcd_rs = rs;
        lcd_rw = 1'b1;
        lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        val = lcd_data_out;
        oe  = lcd_data_oe;
        @(negedge clk);
        lcd_en = 1'b0;
        repeat (6) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic read_disp(input int idx, output logic [7:0] v);
        @(negedge clk);
        disp_addr = 5'(idx);
        @(negedge clk);
        v = disp_char;
    endtask

    task automatic compare_all_cells(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            read_disp(i, v);
            n_checks++;
            if (v !== m_cells[i]) begin
                n_fail++;
                $display("FAIL %s_cell%0d: got %h expected %h", tag, i, v, m_cells[i]);
            end
        end
    endtask

    task automatic status_check(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        logic oe;
        bus_read(1'b0, v, oe);
        n_checks++;
        if (v !== exp || oe !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_status: got %h oe %b expected %h oe 1", tag, v, oe, exp);
        end
    endtask

    task automatic disp_check(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] v;
        read_disp(idx, v);
        n_checks++;
        if (v !== exp) begin
            n_fail++;
            $display("FAIL %s_disp%0d: got %h expected %h", tag, idx, v, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        m_reset();
        #1;
        n_checks++;
        if (busy !== 1'b0 || lcd_data_oe !== 1'b0 || lcd_data_out !== 8'h00 || cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy %b oe %b out %h err %b expected 0 0 00 0",
                     busy, lcd_data_oe, lcd_data_out, cmd_err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (display_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_display_on: got %b expected 0", display_on);
        end
        compare_all_cells("reset");
        status_check("reset", 8'h00);
    endtask

    task automatic test_basic_write();
        bus_write(1'b0, 8'h0C);
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h48);
        bus_write(1'b1, 8'h49);
        n_checks++;
        if (display_on !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_display_on: got %b expected 1", display_on);
        end
        disp_check("basic", 0, 8'h48);
        disp_check("basic", 1, 8'h49);
        status_check("basic", 8'h02);
    endtask

    task automatic test_wrap_discard();
        bus_write(1'b0, 8'hA7);
        bus_write(1'b1, 8'h41);
        bus_write(1'b1, 8'h42);
        disp_check("wrap", 16, 8'h42);
        disp_check("wrap", 15, 8'h20);
        status_check("wrap", 8'h41);
    endtask

    task automatic test_decrement();
        bus_write(1'b0, 8'h04);
        bus_write(1'b0, 8'hC0);
        bus_write(1'b1, 8'h55);
        disp_check("decr", 16, 8'h55);
        status_check("decr", 8'h27);
    endtask

    task automatic test_busy_reject();
        int pulses;
        bit busy_at_err;
        bus_write(1'b0, 8'h06);
        start_strobe(1'b1, 1'b0, 8'h5A, 4);
        wait_busy_rise("reject");
        m_data_write(8'h5A);
        @(negedge clk);
        start_strobe(1'b0, 1'b0, 8'h08, 2);
        pulses = 0;
        busy_at_err = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_err) begin
                pulses++;
                if (!busy) busy_at_err = 1'b0;
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL reject_pulse_count: got %0d expected 1", pulses);
        end
        n_checks++;
        if (busy_at_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_busy: got 0 expected 1 while cmd_err high");
        end
        wait_busy_fall("reject");
        n_checks++;
        if (display_on !== m_disp_on) begin
            n_fail++;
            $display("FAIL reject_display_on: got %b expected %b", display_on, m_disp_on);
        end
        status_check("reject", m_status());
        disp_check("reject", 16, 8'h55);
    endtask

    task automatic test_clear();
        int count;
        bus_write(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) bus_write(1'b1, 8'($urandom_range(33, 126)));
        bus_write(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) bus_write(1'b1, 8'($urandom_range(33, 126)));
        compare_all_cells("fill");
        bus_write(1'b0, 8'h04);
        start_strobe(1'b0, 1'b0, 8'h01, 4);
        wait_busy_rise("clear");
        count = 0;
        do begin
            count++;
            @(negedge clk);
        end while (busy && count < 200);
        m_command(8'h01);
        n_checks++;
        if (count != CLEAR) begin
            n_fail++;
            $display("FAIL clear_busy_len: got %0d expected %0d", count, CLEAR);
        end
        compare_all_cells("clear");
        status_check("clear", 8'h00);
        bus_write(1'b1, 8'h33);
        disp_check("clear_inc", 0, 8'h33);
        status_check("clear_inc", 8'h01);
    endtask

    task automatic test_reset_abort();
        bit seen_busy;
        bus_write(1'b0, 8'h0C);
        bus_write(1'b1, 8'h61);
        bus_write(1'b1, 8'h62);
        start_strobe(1'b0, 1'b0, 8'h01, 4);
        wait_busy_rise("abort");
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        lcd_rs = 1'b1;
        lcd_rw = 1'b0;
        lcd_data_in = 8'h77;
        lcd_en = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || display_on !== 1'b0 || disp_char !== 8'h20 ||
            lcd_data_oe !== 1'b0 || lcd_data_out !== 8'h00 || cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset_values: busy %b disp_on %b char %h oe %b out %h err %b expected 0 0 20 0 00 0",
                     busy, display_on, disp_char, lcd_data_oe, lcd_data_out, cmd_err);
        end
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        lcd_en = 1'b0;
        seen_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        n_checks++;
        if (seen_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stale_strobe: got busy 1 expected 0");
        end
        compare_all_cells("abort");
        status_check("abort", 8'h00);
    endtask

    task automatic test_random_traffic();
        logic [7:0] v;
        logic [7:0] exp;
        logic [7:0] c;
        logic oe;
        for (int n = 0; n < 48; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: bus_write(1'b1, 8'($urandom));
                4: begin
                    case ($urandom_range(0, 2))
                        0:       c = 8'h80 | 8'($urandom_range(0, 15));
                        1:       c = 8'hC0 | 8'($urandom_range(0, 15));
                        default: c = 8'h80 | 8'($urandom_range(0, 127));
                    endcase
                    bus_write(1'b0, c);
                end
                5: bus_write(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
                6: bus_write(1'b0, 8'h08 | 8'($urandom_range(0, 7)));
                7: begin
                    case ($urandom_range(0, 3))
                        0:       c = 8'h10 | 8'($urandom_range(0, 15));
                        1:       c = 8'h02 | 8'($urandom_range(0, 1));
                        2:       c = 8'h20 | 8'($urandom_range(0, 31));
                        default: c = 8'h40 | 8'($urandom_range(0, 63));
                    endcase
                    bus_write(1'b0, c);
                end
                8: begin
                    bus_read(1'b1, v, oe);
                    m_data_read(exp);
                    n_checks++;
                    if (v !== exp || oe !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rand_data_read%0d: got %h oe %b expected %h oe 1", n, v, oe, exp);
                    end
                end
                default: status_check("rand", m_status());
            endcase
        end
        n_checks++;
        if (display_on !== m_disp_on) begin
            n_fail++;
            $display("FAIL rand_display_on: got %b expected %b", display_on, m_disp_on);
        end
        compare_all_cells("rand");
        status_check("rand_final", m_status());
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wrap_discard();
        test_decrement();
        test_busy_reject();
        test_clear();
        test_reset_abort();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
